fft_frame_serializer: RTL and testbench
=======================================

Name: fft_frame_serializer

Overview:
- Parametrised successor to the FFT-to-UART transmit path.
- Buffers complex FFT words of 2*LENGTH bits in an internal FIFO and serialises them into framed byte streams for a UART byte transmitter.
- Framing is sync byte, FRAME_LEN payload words, then an optional checksum byte.
- Run/stop is commanded by received UART bytes; byte width, frame length and FIFO depth are generic.

Parameters:
- LENGTH, 32: bits per real/imag part; 2*LENGTH must be a multiple of 8.
- FRAME_LEN, 256: complex words per frame.
- FIFO_DEPTH, 16: FIFO entries; power of 2, at least 2.
- SIG_RUN, 82: RX byte that enables framing.
- SIG_STOP, 83: RX byte that disables framing.
- SYNC_BYTE, 165: first byte of every frame (0xA5).

Ports:
- i_clk, input, 1: system clock.
- i_rst, input, 1: synchronous, active-low reset.
- i_rx_byte, input, 8: received command byte.
- i_rx_valid, input, 1: i_rx_byte valid, 1-cycle strobe.
- i_fft_data, input, 2*LENGTH: {real, imag} sample.
- i_fft_valid, input, 1: sample valid.
- o_fft_ready, output, 1: FIFO can accept a sample.
- o_tx_byte, output, 8: byte to UART transmitter.
- o_tx_valid, output, 1: o_tx_byte valid.
- i_tx_ready, input, 1: transmitter accepts a byte.
- o_running, output, 1: run state.
- o_frame_start, output, 1: 1-cycle pulse when SYNC_BYTE is handed off.
- o_frame_done, output, 1: 1-cycle pulse when the last frame byte is handed off.

Behaviour:
- Reset (i_rst==0 at a rising edge):
  - FIFO is flushed; state goes to IDLE.
  - o_running=0, o_tx_valid=0, o_tx_byte=0, o_frame_start=0, o_frame_done=0, o_fft_ready=0 during reset.
  - Reset mid-frame abandons the frame; no trailer is sent.
- Input side:
  - A push occurs when i_fft_valid && o_fft_ready; o_fft_ready = !fifo_full, registered.
  - There is no write-through; a pushed word is readable the next cycle.
  - Push at full is impossible by construction. Push and pop in the same cycle are both legal, including at full-1 and empty+1.
- Run control:
  - i_rx_valid && i_rx_byte==SIG_RUN sets o_running the next cycle.
  - SIG_STOP clears it. Any other byte is ignored; RUN while running is a no-op.
  - STOP mid-frame takes effect only at the frame boundary: the current frame always completes.
  - Words keep buffering while stopped until the FIFO is full.
- TX handshake:
  - A transfer occurs when o_tx_valid && i_tx_ready.
  - o_tx_byte and o_tx_valid are held stable until that transfer.
  - o_tx_valid never drops without a transfer, except on reset.
- FSM states and transitions:
  - IDLE: if o_running && !fifo_empty, go to HDR with o_tx_byte=SYNC_BYTE, o_tx_valid=1, checksum=0, word_cnt=0.
  - HDR: on transfer, pulse o_frame_start and go to LOAD.
  - LOAD: wait for !fifo_empty. Pop one word into shift register sreg, present byte 0, byte_cnt=0, go to PAYLOAD. Underrun mid-frame stalls in LOAD with o_tx_valid=0.
  - PAYLOAD: bytes go out MSB first (real MSB to imag LSB); each word is BPW=2*LENGTH/8 bytes. Each transfer XORs the byte into checksum and shifts sreg. After the last byte, word_cnt++. If word_cnt reaches FRAME_LEN go to TRAIL, else go to LOAD.
  - TRAIL: present the checksum byte. On transfer, pulse o_frame_done and go to IDLE.
- Latency: IDLE to o_tx_valid(SYNC) is 1 cycle after the condition holds. Byte-to-byte throughput is 1 byte/cycle when i_tx_ready=1, except 1 bubble cycle per word through LOAD.
- Counter widths: word_cnt is clog2(FRAME_LEN+1); byte_cnt is clog2(BPW).

Optional Feature:
- Macro: FFT_SER_CHECKSUM_EN.
- Defined: TRAIL state present as above.
- Undefined: TRAIL and checksum logic are removed. The last payload byte transfer pulses o_frame_done and goes straight to IDLE; the frame is 1 byte shorter.

Decomposition:
- Shared package/include holds:
  - FSM state encoding (IDLE, HDR, LOAD, PAYLOAD, TRAIL).
  - Default SIG_RUN/SIG_STOP/SYNC_BYTE constants.
  - clog2 function.
- Sub-module sync_fifo (WIDTH, DEPTH): single clock, synchronous active-low reset, full/empty flags, registered read data.

Test Plan (LENGTH=32, FRAME_LEN=2, FIFO_DEPTH=4, checksum enabled):
- Push words 0x0102030405060708 and 0x1112131415161718, send RX byte 82, i_tx_ready=1 -> A5, 01..08, 11..18, then checksum 0x00. o_frame_start pulses once and o_frame_done pulses once.
- Stopped, push 5 words -> o_fft_ready=0 after the 4th accepted word. Nothing transmits until byte 82 is received.
- Send byte 83 after 3 payload bytes -> frame completes with all 18 bytes, o_running=0, no new SYNC follows.
- Toggle i_tx_ready randomly -> o_tx_byte stays stable while o_tx_valid && !i_tx_ready, and the byte sequence is identical to the first case.
- Assert i_rst=0 for 1 cycle mid-payload -> o_tx_valid=0 the next cycle, FIFO empty, o_running=0.
- Without FFT_SER_CHECKSUM_EN -> 17 bytes per frame, o_frame_done coincides with the transfer of the 0x18 byte.

Source files
------------

// File: rtl/fft_frame_serializer_pkg.sv
// Shared FSM encoding, default framing/command bytes and clog2 helper for the FFT frame serializer.
// Optional trailer build switch used by this block: FFT_SER_CHECKSUM_EN.
package fft_frame_serializer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR     = 3'd1,
      ST_LOAD    = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_TRAIL   = 3'd4
   } ser_state_e;

   localparam logic [7:0] DEF_SIG_RUN   = 8'd82;
   localparam logic [7:0] DEF_SIG_STOP  = 8'd83;
   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_frame_serializer_if.sv
// Sample input, command input and byte output bundle of the FFT frame serializer.
// Slave modport is the serializer side, master modport is the producer/transmitter side.
interface fft_frame_serializer_if #(parameter int LENGTH = 32);
   import fft_frame_serializer_pkg::*;

   logic [7:0]          i_rx_byte;
   logic                i_rx_valid;
   logic [2*LENGTH-1:0] i_fft_data;
   logic                i_fft_valid;
   logic                o_fft_ready;
   logic [7:0]          o_tx_byte;
   logic                o_tx_valid;
   logic                i_tx_ready;
   logic                o_running;
   logic                o_frame_start;
   logic                o_frame_done;

   modport slave (
      input  i_rx_byte, i_rx_valid, i_fft_data, i_fft_valid, i_tx_ready,
      output o_fft_ready, o_tx_byte, o_tx_valid, o_running, o_frame_start, o_frame_done
   );

   modport master (
      output i_rx_byte, i_rx_valid, i_fft_data, i_fft_valid, i_tx_ready,
      input  o_fft_ready, o_tx_byte, o_tx_valid, o_running, o_frame_start, o_frame_done
   );

endinterface

// File: rtl/fft_frame_serializer_sync_fifo.sv
// Single-clock show-ahead FIFO with registered read data and a registered write-ready.
// o_data always holds the head entry; a word pushed into an empty FIFO appears the next cycle.
module fft_frame_serializer_sync_fifo
   import fft_frame_serializer_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_wr_ready
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr, w_rd_nxt;
   logic [CW-1:0]    r_count, w_count_nxt;
   logic [WIDTH-1:0] r_data;
   logic             r_full, r_empty, r_wr_ready;
   logic             w_pop;

   assign w_pop    = i_pop && !r_empty;
   assign w_rd_nxt = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

   always_comb begin
      w_count_nxt = r_count;
      if (i_push && !w_pop)      w_count_nxt = r_count + CW'(1);
      else if (!i_push && w_pop) w_count_nxt = r_count - CW'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Head register tracks the next read slot; bypass when that slot is being written now.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_data     <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_wr_ready <= 1'b0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         r_rd_ptr   <= w_rd_nxt;
         r_count    <= w_count_nxt;
         r_data     <= (i_push && (w_rd_nxt == r_wr_ptr)) ? i_data : r_mem[w_rd_nxt];
         r_full     <= (w_count_nxt == FULL_CNT);
         r_empty    <= (w_count_nxt == '0);
         r_wr_ready <= (w_count_nxt != FULL_CNT);
      end
   end

   assign o_data     = r_data;
   assign o_full     = r_full;
   assign o_empty    = r_empty;
   assign o_wr_ready = r_wr_ready;

endmodule

// File: rtl/fft_frame_serializer.sv
// Buffers complex FFT words and sends them as SYNC + FRAME_LEN words (+ XOR checksum byte when
// FFT_SER_CHECKSUM_EN is defined) to a byte transmitter; RX command bytes start/stop framing.
module fft_frame_serializer
   import fft_frame_serializer_pkg::*;
#(
   parameter int         LENGTH     = 32,
   parameter int         FRAME_LEN  = 256,
   parameter int         FIFO_DEPTH = 16,
   parameter logic [7:0] SIG_RUN    = DEF_SIG_RUN,
   parameter logic [7:0] SIG_STOP   = DEF_SIG_STOP,
   parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   fft_frame_serializer_if.slave bus
);

   localparam int W   = 2 * LENGTH;
   localparam int BPW = W / 8;
   localparam int WCW = clog2(FRAME_LEN + 1);
   localparam int BCW = (clog2(BPW) > 0) ? clog2(BPW) : 1;

   ser_state_e     r_state;
   logic           r_running;
   logic [7:0]     r_tx_byte;
   logic           r_tx_valid;
   logic [W-1:0]   r_sreg;
   logic [WCW-1:0] r_word_cnt;
   logic [BCW-1:0] r_byte_cnt;
`ifdef FFT_SER_CHECKSUM_EN
   logic [7:0]     r_cks;
`endif

   logic [W-1:0]   w_fifo_data, w_sreg_shl;
   logic           w_full, w_empty, w_wr_ready;
   logic           w_push, w_pop, w_xfer, w_last_byte, w_last_word;

   assign w_push      = bus.i_fft_valid && w_wr_ready && !w_full;
   assign w_pop       = (r_state == ST_LOAD) && !w_empty;
   assign w_xfer      = r_tx_valid && bus.i_tx_ready;
   assign w_last_byte = (r_byte_cnt == BCW'(BPW - 1));
   assign w_last_word = (r_word_cnt == WCW'(FRAME_LEN - 1));
   assign w_sreg_shl  = r_sreg << 8;

   fft_frame_serializer_sync_fifo #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_push     (w_push),
      .i_data     (bus.i_fft_data),
      .i_pop      (w_pop),
      .o_data     (w_fifo_data),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_wr_ready (w_wr_ready)
   );

   // Run flag follows commands immediately; the FSM only samples it in IDLE, so frames finish.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_running <= 1'b0;
      end else if (bus.i_rx_valid) begin
         if (bus.i_rx_byte == SIG_RUN)       r_running <= 1'b1;
         else if (bus.i_rx_byte == SIG_STOP) r_running <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state    <= ST_IDLE;
         r_tx_byte  <= '0;
         r_tx_valid <= 1'b0;
         r_sreg     <= '0;
         r_word_cnt <= '0;
         r_byte_cnt <= '0;
`ifdef FFT_SER_CHECKSUM_EN
         r_cks      <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: if (r_running && !w_empty) begin
               r_tx_byte  <= SYNC_BYTE;
               r_tx_valid <= 1'b1;
               r_word_cnt <= '0;
`ifdef FFT_SER_CHECKSUM_EN
               r_cks      <= '0;
`endif
               r_state    <= ST_HDR;
            end
            ST_HDR: if (w_xfer) begin
               r_tx_valid <= 1'b0;
               r_state    <= ST_LOAD;
            end
            ST_LOAD: if (!w_empty) begin
               r_sreg     <= w_fifo_data;
               r_tx_byte  <= w_fifo_data[W-1 -: 8];
               r_tx_valid <= 1'b1;
               r_byte_cnt <= '0;
               r_state    <= ST_PAYLOAD;
            end
            ST_PAYLOAD: if (w_xfer) begin
`ifdef FFT_SER_CHECKSUM_EN
               r_cks <= r_cks ^ r_tx_byte;
`endif
               if (w_last_byte) begin
                  r_word_cnt <= r_word_cnt + WCW'(1);
                  if (w_last_word) begin
`ifdef FFT_SER_CHECKSUM_EN
                     r_tx_byte <= r_cks ^ r_tx_byte;
                     r_state   <= ST_TRAIL;
`else
                     r_tx_valid <= 1'b0;
                     r_state    <= ST_IDLE;
`endif
                  end else begin
                     r_tx_valid <= 1'b0;
                     r_state    <= ST_LOAD;
                  end
               end else begin
                  r_sreg     <= w_sreg_shl;
                  r_tx_byte  <= w_sreg_shl[W-1 -: 8];
                  r_byte_cnt <= r_byte_cnt + BCW'(1);
               end
            end
`ifdef FFT_SER_CHECKSUM_EN
            ST_TRAIL: if (w_xfer) begin
               r_tx_valid <= 1'b0;
               r_state    <= ST_IDLE;
            end
`endif
            default: begin
               r_tx_valid <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.o_frame_start = i_rst && w_xfer && (r_state == ST_HDR);
`ifdef FFT_SER_CHECKSUM_EN
   assign bus.o_frame_done  = i_rst && w_xfer && (r_state == ST_TRAIL);
`else
   assign bus.o_frame_done  = i_rst && w_xfer && (r_state == ST_PAYLOAD) && w_last_byte && w_last_word;
`endif

   assign bus.o_fft_ready = w_wr_ready;
   assign bus.o_tx_byte   = r_tx_byte;
   assign bus.o_tx_valid  = r_tx_valid;
   assign bus.o_running   = r_running;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Directed/random bench for fft_frame_serializer (LENGTH=32, FRAME_LEN=2, FIFO_DEPTH=4).
// Expected byte streams come from a frame-level model built from the pushed words.
module tb_fft_frame_serializer;

   localparam int LENGTH    = 32;
   localparam int FRAME_LEN = 2;
   localparam int DEPTH     = 4;
   localparam int BPW       = 8;
`ifdef FFT_SER_CHECKSUM_EN
   localparam bit CKS = 1'b1;
`else
   localparam bit CKS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fft_frame_serializer_if #(.LENGTH(LENGTH)) bus();

   fft_frame_serializer #(
      .LENGTH     (LENGTH),
      .FRAME_LEN  (FRAME_LEN),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   logic [7:0] rxq[$];
   logic [7:0] expq[$];
   int         start_cnt = 0, done_cnt = 0, start_bad = 0, done_bad = 0, stab_err = 0;
   logic [7:0] last_start_byte = '0, last_done_byte = '0;
   logic       hold_p = 1'b0;
   logic [7:0] hold_b = '0;

   // Observe at the falling edge: a valid&&ready seen here is the transfer at the next rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         hold_p <= 1'b0;
      end else begin
         if (hold_p && (!bus.o_tx_valid || bus.o_tx_byte != hold_b)) stab_err <= stab_err + 1;
         hold_p <= bus.o_tx_valid && !bus.i_tx_ready;
         hold_b <= bus.o_tx_byte;
         if (bus.o_tx_valid && bus.i_tx_ready) rxq.push_back(bus.o_tx_byte);
         if (bus.o_frame_start) begin
            start_cnt       <= start_cnt + 1;
            last_start_byte <= bus.o_tx_byte;
            if (!(bus.o_tx_valid && bus.i_tx_ready)) start_bad <= start_bad + 1;
         end
         if (bus.o_frame_done) begin
            done_cnt       <= done_cnt + 1;
            last_done_byte <= bus.o_tx_byte;
            if (!(bus.o_tx_valid && bus.i_tx_ready)) done_bad <= done_bad + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] w, output bit ok);
      ok = 1'b0;
      bus.i_fft_data  = w;
      bus.i_fft_valid = 1'b1;
      for (int c = 0; c < 8 && !ok; c++) begin
         @(negedge clk);
         if (bus.o_fft_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      bus.i_fft_valid = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b);
      bus.i_rx_byte  = b;
      bus.i_rx_valid = 1'b1;
      tick(1);
      bus.i_rx_valid = 1'b0;
   endtask

   // Frame model: SYNC, each word MSB byte first, then XOR of payload bytes when enabled.
   function automatic void exp_frame(input logic [63:0] a, input logic [63:0] b);
      logic [63:0] w [2];
      logic [7:0]  cks, byt;
      w[0] = a;
      w[1] = b;
      cks  = 8'h00;
      expq.push_back(8'hA5);
      for (int i = 0; i < FRAME_LEN; i++) begin
         for (int k = 0; k < BPW; k++) begin
            byt = 8'((w[i] >> (8 * (BPW - 1 - k))) & 64'hFF);
            expq.push_back(byt);
            cks = cks ^ byt;
         end
      end
      if (CKS) expq.push_back(cks);
   endfunction

   task automatic cmp_stream(input string tag);
      check($sformatf("%s_len", tag), 64'(rxq.size()), 64'(expq.size()));
      for (int i = 0; i < expq.size() && i < rxq.size(); i++)
         check($sformatf("%s_b%0d", tag, i), 64'(rxq[i]), 64'(expq[i]));
   endtask

   task automatic wait_done(input int target, input string tag);
      int c;
      c = 0;
      while (done_cnt < target && c < 400) begin
         tick(1);
         c++;
      end
      check($sformatf("%s_timeout", tag), 64'(done_cnt >= target), 64'd1);
   endtask

   initial begin
      logic [63:0] w0, w1;
      logic [63:0] acc [4];
      int          n_acc, s0, d0, c;
      bit          ok;

      bus.i_rx_byte   = '0;
      bus.i_rx_valid  = 1'b0;
      bus.i_fft_data  = '0;
      bus.i_fft_valid = 1'b0;
      bus.i_tx_ready  = 1'b1;
      w0 = 64'h0102030405060708;
      w1 = 64'h1112131415161718;

      // Reset state
      tick(2);
      check("rst_tx_valid", 64'(bus.o_tx_valid), 64'd0);
      check("rst_tx_byte", 64'(bus.o_tx_byte), 64'd0);
      check("rst_running", 64'(bus.o_running), 64'd0);
      check("rst_fft_ready", 64'(bus.o_fft_ready), 64'd0);
      check("rst_frame_start", 64'(bus.o_frame_start), 64'd0);
      check("rst_frame_done", 64'(bus.o_frame_done), 64'd0);
      rst = 1'b1;
      tick(1);
      check("post_rst_fft_ready", 64'(bus.o_fft_ready), 64'd1);

      // Basic frame with the reference words
      push(w0, ok); check("t1_push0", 64'(ok), 64'd1);
      push(w1, ok); check("t1_push1", 64'(ok), 64'd1);
      rxq.delete(); expq.delete(); exp_frame(w0, w1);
      s0 = start_cnt; d0 = done_cnt;
      send_rx(8'd82);
      check("t1_running", 64'(bus.o_running), 64'd1);
      wait_done(d0 + 1, "t1");
      tick(2);
      cmp_stream("t1");
      check("t1_starts", 64'(start_cnt - s0), 64'd1);
      check("t1_dones", 64'(done_cnt - d0), 64'd1);
      check("t1_start_byte", 64'(last_start_byte), 64'hA5);
      check("t1_done_byte", 64'(last_done_byte), CKS ? 64'h00 : 64'h18);
      send_rx(8'd83);
      check("t1_stop", 64'(bus.o_running), 64'd0);
      send_rx(8'h41);
      check("ignored_byte", 64'(bus.o_running), 64'd0);

      // Stopped: buffer until full, nothing sent until RUN
      n_acc = 0;
      rxq.delete();
      for (int i = 0; i < 5; i++) begin
         push({$urandom(), $urandom()}, ok);
         if (ok) begin
            acc[n_acc] = bus.i_fft_data;
            n_acc++;
         end
      end
      check("t2_accepted", 64'(n_acc), 64'd4);
      check("t2_fft_ready_full", 64'(bus.o_fft_ready), 64'd0);
      tick(20);
      check("t2_silent", 64'(rxq.size()), 64'd0);
      expq.delete();
      exp_frame(acc[0], acc[1]);
      exp_frame(acc[2], acc[3]);
      d0 = done_cnt;
      send_rx(8'd82);
      wait_done(d0 + 2, "t2");
      tick(2);
      cmp_stream("t2");
      check("t2_fft_ready_drained", 64'(bus.o_fft_ready), 64'd1);
      send_rx(8'd83);

      // STOP mid-frame: current frame completes, no new SYNC
      for (int i = 0; i < 4; i++) begin
         push({$urandom(), $urandom()}, ok);
         acc[i] = bus.i_fft_data;
      end
      rxq.delete(); expq.delete(); exp_frame(acc[0], acc[1]);
      s0 = start_cnt; d0 = done_cnt;
      send_rx(8'd82);
      c = 0;
      while (rxq.size() < 4 && c < 100) begin tick(1); c++; end
      check("t3_reach_payload", 64'(rxq.size() >= 4), 64'd1);
      send_rx(8'd83);
      wait_done(d0 + 1, "t3");
      tick(40);
      cmp_stream("t3");
      check("t3_running", 64'(bus.o_running), 64'd0);
      check("t3_one_sync", 64'(start_cnt - s0), 64'd1);

      // Random back-pressure; leftover words are flushed by reset first
      rst = 1'b0; tick(2); rst = 1'b1; tick(1);
      push(w0, ok); push(w1, ok);
      rxq.delete(); expq.delete(); exp_frame(w0, w1);
      d0 = done_cnt;
      bus.i_rx_byte = 8'd82; bus.i_rx_valid = 1'b1;
      tick(1);
      bus.i_rx_valid = 1'b0;
      c = 0;
      while (done_cnt < d0 + 1 && c < 600) begin
         bus.i_tx_ready = 1'($urandom_range(0, 1));
         tick(1);
         c++;
      end
      check("t4_timeout", 64'(done_cnt >= d0 + 1), 64'd1);
      bus.i_tx_ready = 1'b1;
      tick(2);
      cmp_stream("t4");
      check("t4_stable", 64'(stab_err), 64'd0);
      send_rx(8'd83);

      // Reset mid-payload abandons the frame and flushes the FIFO
      push({$urandom(), $urandom()}, ok);
      push({$urandom(), $urandom()}, ok);
      rxq.delete();
      send_rx(8'd82);
      c = 0;
      while (rxq.size() < 3 && c < 100) begin tick(1); c++; end
      check("t5_reach_payload", 64'(rxq.size() >= 3), 64'd1);
      rst = 1'b0;
      tick(1);
      check("t5_tx_valid", 64'(bus.o_tx_valid), 64'd0);
      check("t5_running", 64'(bus.o_running), 64'd0);
      check("t5_fft_ready", 64'(bus.o_fft_ready), 64'd0);
      rst = 1'b1;
      tick(1);
      rxq.delete();
      send_rx(8'd82);
      tick(30);
      check("t5_fifo_flushed", 64'(rxq.size()), 64'd0);
      push({$urandom(), $urandom()}, ok); acc[0] = bus.i_fft_data;
      push({$urandom(), $urandom()}, ok); acc[1] = bus.i_fft_data;
      expq.delete(); exp_frame(acc[0], acc[1]);
      d0 = done_cnt;
      wait_done(d0 + 1, "t5");
      tick(2);
      cmp_stream("t5");

      check("start_coincident", 64'(start_bad), 64'd0);
      check("done_coincident", 64'(done_bad), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
